// File: rtl/vga_pixel_gen.sv
// Pixel stage behind the VGA sync generator: background pattern plus a bouncing box,
// two-stage pipeline with sync outputs kept aligned to colour, box moves once per frame.
module vga_pixel_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned BOX_SIZE  = 32,
    parameter int unsigned STEP      = 4,
    parameter logic [11:0] BOX_COLOR = 12'hFFF
) (
    input  logic        CLK,
    input  logic        SYNC_RST_N,
    input  logic        H_SYNC_IN,
    input  logic        V_SYNC_IN,
    input  logic [10:0] iCurrent_X,
    input  logic [10:0] iCurrent_Y,
    input  logic        iSYNC_COLOR,
    input  logic [1:0]  iMODE,
    input  logic        iPAUSE,
    output logic        H_SYNC_OUT,
    output logic        V_SYNC_OUT,
    output logic [3:0]  oRED,
    output logic [3:0]  oGREEN,
    output logic [3:0]  oBLUE,
    output logic        oFRAME_TICK
);

    localparam logic [11:0] LIMIT_X   = 12'(H_ACTIVE - BOX_SIZE);
    localparam logic [11:0] LIMIT_Y   = 12'(V_ACTIVE - BOX_SIZE);
    localparam logic [11:0] STEP_W    = 12'(STEP);
    localparam logic [10:0] STEP_N    = 11'(STEP);
    localparam logic [11:0] BOX_W     = 12'(BOX_SIZE);

    // Bar k starts at the first X where X*8/H_ACTIVE reaches k (ceiling of k*H_ACTIVE/8).
    localparam logic [11:0] BAR1 = 12'((1 * H_ACTIVE + 7) / 8);
    localparam logic [11:0] BAR2 = 12'((2 * H_ACTIVE + 7) / 8);
    localparam logic [11:0] BAR3 = 12'((3 * H_ACTIVE + 7) / 8);
    localparam logic [11:0] BAR4 = 12'((4 * H_ACTIVE + 7) / 8);
    localparam logic [11:0] BAR5 = 12'((5 * H_ACTIVE + 7) / 8);
    localparam logic [11:0] BAR6 = 12'((6 * H_ACTIVE + 7) / 8);
    localparam logic [11:0] BAR7 = 12'((7 * H_ACTIVE + 7) / 8);

    logic [10:0] xS1_q, yS1_q;
    logic        activeS1_q, hsS1_q, vsS1_q;

    logic [11:0] rgb_q, rgb_d;
    logic        hsOut_q, vsOut_q, tick_q;

    logic [10:0] boxX_q, boxX_d, boxY_q, boxY_d;
    logic        dirRight_q, dirRight_d, dirDown_q, dirDown_d;
    logic [1:0]  mode_q, mode_d;

    logic        tickDet;
    logic [11:0] xExt, yExt, boxXExt, boxYExt;
    logic [11:0] barColor, bgColor;
    logic        boxHit;

    // The stage-1 V sync register doubles as the edge-detect history; it resets high.
    assign tickDet = vsS1_q & ~V_SYNC_IN;

    always_comb begin
        boxX_d     = boxX_q;
        boxY_d     = boxY_q;
        dirRight_d = dirRight_q;
        dirDown_d  = dirDown_q;
        mode_d     = mode_q;
        if (tickDet) begin
            mode_d = iMODE;
            if (!iPAUSE) begin
                if (dirRight_q) begin
                    if ({1'b0, boxX_q} + STEP_W >= LIMIT_X) begin
                        boxX_d     = LIMIT_X[10:0];
                        dirRight_d = 1'b0;
                    end else begin
                        boxX_d = boxX_q + STEP_N;
                    end
                end else begin
                    if ({1'b0, boxX_q} <= STEP_W) begin
                        boxX_d     = '0;
                        dirRight_d = 1'b1;
                    end else begin
                        boxX_d = boxX_q - STEP_N;
                    end
                end
                if (dirDown_q) begin
                    if ({1'b0, boxY_q} + STEP_W >= LIMIT_Y) begin
                        boxY_d    = LIMIT_Y[10:0];
                        dirDown_d = 1'b0;
                    end else begin
                        boxY_d = boxY_q + STEP_N;
                    end
                end else begin
                    if ({1'b0, boxY_q} <= STEP_W) begin
                        boxY_d    = '0;
                        dirDown_d = 1'b1;
                    end else begin
                        boxY_d = boxY_q - STEP_N;
                    end
                end
            end
        end
    end

    always_comb begin
        xExt    = {1'b0, xS1_q};
        yExt    = {1'b0, yS1_q};
        boxXExt = {1'b0, boxX_q};
        boxYExt = {1'b0, boxY_q};

        if      (xExt < BAR1) barColor = 12'hFFF;
        else if (xExt < BAR2) barColor = 12'hFF0;
        else if (xExt < BAR3) barColor = 12'h0FF;
        else if (xExt < BAR4) barColor = 12'h0F0;
        else if (xExt < BAR5) barColor = 12'hF0F;
        else if (xExt < BAR6) barColor = 12'hF00;
        else if (xExt < BAR7) barColor = 12'h00F;
        else                  barColor = 12'h000;

        case (mode_q)
            2'd0:    bgColor = barColor;
            2'd1:    bgColor = (xS1_q[4] ^ yS1_q[4]) ? 12'hFFF : 12'h000;
            2'd2:    bgColor = 12'h000;
            default: bgColor = ((xS1_q[4:0] == 5'd0) || (yS1_q[4:0] == 5'd0)) ? 12'hFFF : 12'h000;
        endcase

        boxHit = (xExt >= boxXExt) && (xExt < boxXExt + BOX_W) &&
                 (yExt >= boxYExt) && (yExt < boxYExt + BOX_W);

        if (!activeS1_q)  rgb_d = 12'h000;
        else if (boxHit)  rgb_d = BOX_COLOR;
        else              rgb_d = bgColor;
    end

    always_ff @(posedge CLK or negedge SYNC_RST_N) begin
        if (!SYNC_RST_N) begin
            xS1_q      <= '0;
            yS1_q      <= '0;
            activeS1_q <= 1'b0;
            hsS1_q     <= 1'b1;
            vsS1_q     <= 1'b1;
            rgb_q      <= '0;
            hsOut_q    <= 1'b1;
            vsOut_q    <= 1'b1;
            tick_q     <= 1'b0;
            boxX_q     <= '0;
            boxY_q     <= '0;
            dirRight_q <= 1'b1;
            dirDown_q  <= 1'b1;
            mode_q     <= '0;
        end else begin
            xS1_q      <= iCurrent_X;
            yS1_q      <= iCurrent_Y;
            activeS1_q <= iSYNC_COLOR;
            hsS1_q     <= H_SYNC_IN;
            vsS1_q     <= V_SYNC_IN;
            rgb_q      <= rgb_d;
            hsOut_q    <= hsS1_q;
            vsOut_q    <= vsS1_q;
            tick_q     <= tickDet;
            boxX_q     <= boxX_d;
            boxY_q     <= boxY_d;
            dirRight_q <= dirRight_d;
            dirDown_q  <= dirDown_d;
            mode_q     <= mode_d;
        end
    end

    assign H_SYNC_OUT  = hsOut_q;
    assign V_SYNC_OUT  = vsOut_q;
    assign oRED        = rgb_q[11:8];
    assign oGREEN      = rgb_q[7:4];
    assign oBLUE       = rgb_q[3:0];
    assign oFRAME_TICK = tick_q;

endmodule

// File: doc/vga_pixel_gen.md
# vga_pixel_gen

Pixel-generation stage that sits directly downstream of the VGA sync generator. It consumes the generator's H/V sync, current X/Y coordinates and active-video flag, and produces 4-bit-per-channel RGB plus pipeline-aligned sync outputs for the DAC/connector. Content is a selectable background pattern with a bouncing box overlaid; the box position advances once per frame.

## Interface
- H_ACTIVE, 640, active pixels per line; width of the coordinate space.
- V_ACTIVE, 480, active lines per frame.
- BOX_SIZE, 32, box edge length in pixels; must be < H_ACTIVE and < V_ACTIVE.
- STEP, 4, box movement per frame in pixels, both axes; must be ≥ 1.
- BOX_COLOR, 12'hFFF, box colour as {R,G,B}, 4 bits each.

Ports:
- CLK  in  1  pixel clock; same clock as the sync generator.
- SYNC_RST_N  in  1  asynchronous active-low reset.
- H_SYNC_IN  in  1  horizontal sync from the generator, active low.
- V_SYNC_IN  in  1  vertical sync from the generator, active low.
- iCurrent_X  in  11  active-region X coordinate; 0 during blanking.
- iCurrent_Y  in  11  active-region Y coordinate; 0 during blanking.
- iSYNC_COLOR  in  1  1 = active video pixel.
- iMODE  in  2  background select; sampled only on the frame tick.
- iPAUSE  in  1  1 = box frozen; sampled only on the frame tick.
- H_SYNC_OUT  out  1  H_SYNC_IN delayed 2 cycles.
- V_SYNC_OUT  out  1  V_SYNC_IN delayed 2 cycles.
- oRED, oGREEN, oBLUE  out  4 each  pixel colour.
- oFRAME_TICK  out  1  one-cycle pulse per frame.

## Operation
- Clocking: one clock (CLK); reset is asynchronous and active-low (SYNC_RST_N). All state is reset asynchronously.
- Reset values: H_SYNC_OUT=1, V_SYNC_OUT=1, RGB=0, oFRAME_TICK=0, box X=0, box Y=0, X direction=right, Y direction=down, latched mode=0, V-sync history register=1. Because the history register resets to 1, reset never creates a false tick.
- Frame tick: V_SYNC_IN is registered. A tick is asserted when the registered value is 1 and the current value is 0, i.e. on the falling edge. oFRAME_TICK is high for exactly 1 cycle, the cycle after the edge is seen.
- On a tick:
  - latched mode ← iMODE.
  - If iPAUSE=0, box X and box Y update independently.
  - Moving right/down: if pos + STEP ≥ LIMIT, then pos ← LIMIT and direction flips; otherwise pos ← pos + STEP. LIMIT is H_ACTIVE−BOX_SIZE for X and V_ACTIVE−BOX_SIZE for Y.
  - Moving left/up: if pos ≤ STEP, then pos ← 0 and direction flips; otherwise pos ← pos − STEP.
  - Positions are 11-bit unsigned and never leave [0, LIMIT].
- Mode and box position never change outside a tick, so there is no tearing mid-frame.
- Background patterns, by latched mode:
  - 0, colour bars: 8 vertical bars, bar index = X·8/H_ACTIVE, giving 80 px bars at 640. Colours in order: white FFF, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000. Implement with a comparator chain; no divider.
  - 1, checkerboard: X[4]^Y[4] ? FFF : 000.
  - 2, solid black 000.
  - 3, grid: FFF where X[4:0]==0 or Y[4:0]==0, else 000.
- Box overlay: BOX_COLOR replaces the background where boxX ≤ X < boxX+BOX_SIZE and boxY ≤ Y < boxY+BOX_SIZE. This applies in every mode.
- Blanking: RGB=000 whenever the pipelined iSYNC_COLOR=0, regardless of X/Y.

## Timing
- Stage 1: register iCurrent_X, iCurrent_Y, iSYNC_COLOR, H_SYNC_IN and V_SYNC_IN.
- Stage 2: compute the pattern, box hit and blanking from the stage-1 values, then register RGB and the syncs.
- Latency: an input presented at cycle n appears on RGB and the sync outputs at cycle n+2. Syncs and colour stay exactly aligned.
- The box position used in stage 2 is the registered value. A tick and a pixel in the same cycle use the pre-update position; in practice ticks fall in vertical blank.
- Reset mid-frame: outputs go to reset values immediately. After release, the first tick is the next V_SYNC_IN falling edge.
- iMODE/iPAUSE changes between ticks have no visible effect until the next tick.

## Test plan
- Reset: assert SYNC_RST_N=0 mid-line → H/V_SYNC_OUT=1, RGB=000, oFRAME_TICK=0 asynchronously. Release → no tick until V_SYNC_IN falls.
- Latency/bars (mode 0, box parked off-pixel): present X=0 then X=85, Y=200, active=1 → RGB FFF and then FF0, each 2 cycles after input. H_SYNC_IN pulse emerges 2 cycles later, aligned.
- Blanking: iSYNC_COLOR=0 with X=100, Y=100 inside the box → RGB=000 after 2 cycles.
- Bounce: defaults, 152 ticks → boxX=608, direction left; tick 153 → boxX=604. Y reaches 448 on tick 112, then 444 on tick 113.
- Pause/mode latch: iPAUSE=1 across 5 ticks → position unchanged. Change iMODE 0→1 mid-frame → bars persist until the next tick, then checkerboard (X=16, Y=0 → FFF).
- Box overlay: after 1 tick (box at 4,4), pixel X=4,Y=4 → BOX_COLOR. Pixels X=3 and X=36 on the same line → background colour.
